// File: rtl/dcache_adaptor_pkg.sv
// Shared types and default sizes for the dcache line <-> memory beat adaptor.
package dcache_adaptor_pkg;

  localparam int BEAT_W_DEF = 64;
  localparam int LINE_W_DEF = 256;
  localparam int BEATS_DEF  = LINE_W_DEF / BEAT_W_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/dcache_line_adaptor.sv
// Splits a dcache line write-back into memory beats and assembles memory
// read beats into a fill line. One request in flight at a time; a one-cycle
// resp_o pulse marks completion.
// Optional build macro: DCACHE_ADAPTOR_ADDR_ALIGN_EN forces address_o[4:0]
// to zero so memory always sees a line-aligned address.
module dcache_line_adaptor
  import dcache_adaptor_pkg::*;
#(
  parameter int BEAT_W = BEAT_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  input  logic [31:0]       address_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic              resp_o,
  input  logic [BEAT_W-1:0] burst_i,
  output logic [BEAT_W-1:0] burst_o,
  output logic [31:0]       address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [LINE_W-1:0]  line_buf;
  logic [31:0]        addr_q;
  logic [31:0]        addr_in;
  logic               last_beat;

`ifdef DCACHE_ADAPTOR_ADDR_ALIGN_EN
  assign addr_in = {address_i[31:5], 5'b0};
`else
  assign addr_in = address_i;
`endif

  assign last_beat = resp_i && (cnt == LAST);

  // State register; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: write wins over read; DONE never accepts, so a request held
  // through DONE is only taken from IDLE on the following cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (write_i)     state_nxt = WR;
        else if (read_i) state_nxt = RD;
      end
      RD:      if (last_beat) state_nxt = DONE;
      WR:      if (last_beat) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch request on acceptance, then move one beat per resp_i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      addr_q   <= '0;
      line_buf <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write_i || read_i) begin
            cnt    <= '0;
            addr_q <= addr_in;
            if (write_i) line_buf <= line_i;
          end
        end
        RD: begin
          if (resp_i) begin
            line_buf[cnt*BEAT_W +: BEAT_W] <= burst_i;
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
          end
        end
        WR: begin
          if (resp_i) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs are pure decodes of state/counter/buffer, so reset clears them
  // immediately along with the registers.
  always_comb begin
    read_o    = 1'b0;
    write_o   = 1'b0;
    resp_o    = 1'b0;
    burst_o   = '0;
    line_o    = line_buf;
    address_o = addr_q;
    case (state)
      RD:   read_o  = 1'b1;
      WR: begin
        write_o = 1'b1;
        burst_o = line_buf[cnt*BEAT_W +: BEAT_W];
      end
      DONE: resp_o  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_line_adaptor.sv
// Directed bench for dcache_line_adaptor at default sizes (4 x 64-bit beats).
module tb_dcache_line_adaptor;

  logic         clk;
  logic         rst_n;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int checks;
  int failures;

  dcache_line_adaptor dut (
    .clk(clk), .rst_n(rst_n), .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i),
    .resp_o(resp_o), .burst_i(burst_i), .burst_o(burst_o),
    .address_o(address_o), .read_o(read_o), .write_o(write_o),
    .resp_i(resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if ({read_o, write_o, resp_o} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=000", {read_o, write_o, resp_o});
    end
    checks++;
    if (address_o !== 32'h0 || line_o !== 256'h0 || burst_o !== 64'h0) begin
      failures++;
      $display("FAIL reset_data addr=%h line=%h burst=%h want all zero", address_o, line_o, burst_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  // Read with resp_i held high: 4 beats, resp_o on 5th edge after acceptance.
  task automatic test_read();
    logic [255:0] exp_line;
    exp_line = {64'h3, 64'h2, 64'h1, 64'h0};
    address_i = 32'h0000_0100;
    read_i = 1'b1; resp_i = 1'b1; burst_i = 64'h0;
    step();
    read_i = 1'b0;
    checks++;
    if (read_o !== 1'b1 || write_o !== 1'b0 || address_o !== 32'h0000_0100) begin
      failures++;
      $display("FAIL read_start read_o=%b write_o=%b addr=%h want 1 0 00000100", read_o, write_o, address_o);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (resp_o !== 1'b0) begin
        failures++;
        $display("FAIL read_early_resp beat=%0d got=%b want=0", k, resp_o);
      end
      burst_i = 64'(k);
      step();
    end
    checks++;
    if (resp_o !== 1'b1 || read_o !== 1'b0 || line_o !== exp_line) begin
      failures++;
      $display("FAIL read_done resp=%b read_o=%b line=%h want 1 0 %h", resp_o, read_o, line_o, exp_line);
    end
    resp_i = 1'b0;
    step();
    checks++;
    if (resp_o !== 1'b0 || line_o !== exp_line) begin
      failures++;
      $display("FAIL read_hold resp=%b line=%h want 0 %h", resp_o, line_o, exp_line);
    end
  endtask

  // Write with resp_i toggling 1,0,1,0...; line_i changed mid-burst must not matter.
  task automatic test_write();
    logic [63:0] words [4];
    int done_beats;
    words[0] = 64'hAAAA_AAAA_AAAA_AAAA;
    words[1] = 64'hBBBB_BBBB_BBBB_BBBB;
    words[2] = 64'hCCCC_CCCC_CCCC_CCCC;
    words[3] = 64'hDDDD_DDDD_DDDD_DDDD;
    line_i = {words[3], words[2], words[1], words[0]};
    address_i = 32'h0000_0200;
    write_i = 1'b1; resp_i = 1'b0;
    step();
    write_i = 1'b0;
    line_i = '1;
    address_i = 32'hFFFF_FFFF;
    done_beats = 0;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (write_o !== 1'b1 || resp_o !== 1'b0 || burst_o !== words[done_beats]) begin
        failures++;
        $display("FAIL write_beat i=%0d write_o=%b resp=%b burst=%h want 1 0 %h", i, write_o, resp_o, burst_o, words[done_beats]);
      end
      resp_i = (i % 2 == 0);
      if (resp_i) done_beats++;
      step();
    end
    checks++;
    if (resp_o !== 1'b1 || write_o !== 1'b0 || address_o !== 32'h0000_0200) begin
      failures++;
      $display("FAIL write_done resp=%b write_o=%b addr=%h want 1 0 00000200", resp_o, write_o, address_o);
    end
    resp_i = 1'b0;
    step();
  endtask

  // Both requests high: write wins; address latched (aligned when enabled).
  task automatic test_priority();
    logic [31:0] exp_addr;
`ifdef DCACHE_ADAPTOR_ADDR_ALIGN_EN
    exp_addr = 32'h1234_5660;
`else
    exp_addr = 32'h1234_5678;
`endif
    line_i = {64'h4, 64'h3, 64'h2, 64'h1};
    address_i = 32'h1234_5678;
    read_i = 1'b1; write_i = 1'b1; resp_i = 1'b1;
    step();
    read_i = 1'b0; write_i = 1'b0;
    checks++;
    if (write_o !== 1'b1 || read_o !== 1'b0 || address_o !== exp_addr || burst_o !== 64'h1) begin
      failures++;
      $display("FAIL priority write_o=%b read_o=%b addr=%h burst=%h want 1 0 %h 1", write_o, read_o, address_o, burst_o, exp_addr);
    end
    for (int k = 0; k < 4; k++) step();
    checks++;
    if (resp_o !== 1'b1) begin
      failures++;
      $display("FAIL priority_done resp=%b want=1", resp_o);
    end
    resp_i = 1'b0;
    step();
  endtask

  // Reset after two read beats, then a clean read with fresh data.
  task automatic test_reset_mid();
    logic [255:0] exp_line;
    exp_line = {64'h8, 64'h7, 64'h6, 64'h5};
    address_i = 32'h0000_0300;
    read_i = 1'b1; resp_i = 1'b1; burst_i = 64'h11;
    step();
    read_i = 1'b0;
    step();
    burst_i = 64'h22;
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({read_o, write_o, resp_o} !== 3'b000 || address_o !== 32'h0 || line_o !== 256'h0 || burst_o !== 64'h0) begin
      failures++;
      $display("FAIL reset_mid ctrl=%b addr=%h line=%h burst=%h want all zero", {read_o, write_o, resp_o}, address_o, line_o, burst_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    resp_i = 1'b1;
    step();
    checks++;
    if (read_o !== 1'b0 || resp_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_resume read_o=%b resp=%b want 0 0", read_o, resp_o);
    end
    read_i = 1'b1; burst_i = 64'h5;
    step();
    read_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      burst_i = 64'(5 + k);
      step();
    end
    checks++;
    if (resp_o !== 1'b1 || line_o !== exp_line) begin
      failures++;
      $display("FAIL reset_reread resp=%b line=%h want 1 %h", resp_o, line_o, exp_line);
    end
    resp_i = 1'b0;
    step();
  endtask

  // read_i held through DONE: one pulse, next burst starts only from IDLE.
  task automatic test_hold_done();
    int pulses;
    pulses = 0;
    address_i = 32'h0000_0400;
    read_i = 1'b1; resp_i = 1'b1; burst_i = 64'h9;
    for (int e = 0; e < 6; e++) begin
      step();
      if (resp_o === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1 || read_o !== 1'b0 || resp_o !== 1'b0) begin
      failures++;
      $display("FAIL hold_done pulses=%0d read_o=%b resp=%b want 1 0 0", pulses, read_o, resp_o);
    end
    step();
    checks++;
    if (read_o !== 1'b1) begin
      failures++;
      $display("FAIL hold_restart read_o=%b want=1", read_o);
    end
    read_i = 1'b0;
    for (int k = 0; k < 4; k++) step();
    resp_i = 1'b0;
    step();
  endtask

  // resp_i in IDLE must not move anything.
  task automatic test_idle_resp();
    logic [255:0] held;
    held = line_o;
    resp_i = 1'b1; burst_i = 64'hDEAD;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({read_o, write_o, resp_o} !== 3'b000 || line_o !== held) begin
        failures++;
        $display("FAIL idle_resp k=%0d ctrl=%b line=%h want 000 %h", k, {read_o, write_o, resp_o}, line_o, held);
      end
    end
    resp_i = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    burst_i = '0; resp_i = 1'b0;
    #12;
    test_reset();
    test_read();
    test_write();
    test_priority();
    test_reset_mid();
    test_hold_done();
    test_idle_resp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
